// File: rtl/operand_pkg.sv
// operand_pkg: shared states, dimension constants and address composition for operand_loader
package operand_pkg;
    localparam int MAX_DIM = 4;
    localparam int DIM_W = $clog2(MAX_DIM) + 1;
    typedef enum logic [1:0] {IDLE, LOAD, PAD, DONE} state_e;
    function automatic int unsigned addr_of(input int unsigned row, input int unsigned col, input int unsigned pitch);
        return row * pitch + col;
    endfunction
endpackage

// File: rtl/operand_addr_gen.sv
// operand_addr_gen: row/col counters, last-element flag and zero-pad address scan (OPERAND_ZERO_PAD_EN)
module operand_addr_gen #(
    parameter int ADDR_WIDTH = 4,
    parameter int MAX_DIM = 4,
    parameter int DIM_W = $clog2(MAX_DIM) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  step_i,
    input  logic [DIM_W-1:0]      n_rows_i,
    input  logic [DIM_W-1:0]      n_cols_i,
`ifdef OPERAND_ZERO_PAD_EN
    input  logic                  pad_start_i,
    input  logic                  pad_step_i,
    output logic [ADDR_WIDTH-1:0] pad_addr_o,
    output logic                  pad_any_o,
    output logic                  pad_last_o,
`endif
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);
    import operand_pkg::*;
    logic [DIM_W-1:0] row_q, row_d, col_q, col_d;
    logic col_wrap;
    assign col_wrap = col_q == n_cols_i - DIM_W'(1);
    assign last_o = col_wrap && row_q == n_rows_i - DIM_W'(1);
    assign addr_o = ADDR_WIDTH'(addr_of(32'(row_q), 32'(col_q), MAX_DIM));
    always_comb begin
        col_d = clear_i ? '0 : step_i ? (col_wrap ? '0 : col_q + DIM_W'(1)) : col_q;
        row_d = clear_i ? '0 : (step_i && col_wrap) ? row_q + DIM_W'(1) : row_q;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end
`ifdef OPERAND_ZERO_PAD_EN
    localparam int CELLS = MAX_DIM * MAX_DIM;
    logic [ADDR_WIDTH-1:0] pad_q, pad_d, pad_first, pad_next;
    logic hit, pad_found, pad_more;
    // Downward scan leaves the lowest pad address overall and the lowest one above pad_q.
    always_comb begin
        hit = 1'b0;
        pad_first = '0;
        pad_next = '0;
        pad_found = 1'b0;
        pad_more = 1'b0;
        for (int a = CELLS - 1; a >= 0; a--) begin
            hit = (a / MAX_DIM >= int'(n_rows_i)) || (a % MAX_DIM >= int'(n_cols_i));
            if (hit) begin
                pad_first = ADDR_WIDTH'(a);
                pad_found = 1'b1;
            end
            if (hit && a > int'(pad_q)) begin
                pad_next = ADDR_WIDTH'(a);
                pad_more = 1'b1;
            end
        end
        pad_d = pad_start_i ? pad_first : pad_step_i ? pad_next : pad_q;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) pad_q <= '0;
        else pad_q <= pad_d;
    end
    assign pad_addr_o = pad_q;
    assign pad_any_o = pad_found;
    assign pad_last_o = !pad_more;
`endif
endmodule

// File: rtl/operand_loader.sv
// operand_loader: loads a streamed matrix into the operand register file; OPERAND_ZERO_PAD_EN zero-fills unused entries
module operand_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int MAX_DIM = 4,
    parameter int DIM_W = $clog2(MAX_DIM) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DIM_W-1:0]      n_rows_i,
    input  logic [DIM_W-1:0]      n_cols_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [DATA_WIDTH-1:0] write_data_Mat_o,
    output logic [ADDR_WIDTH-1:0] addr_Mat_o,
    output logic                  write_en_Mat_o
);
    import operand_pkg::*;
    state_e state_q, state_d;
    logic [DIM_W-1:0] rows_q, rows_d, cols_q, cols_d;
    logic err_q, err_d, done_q, done_d, busy_q, busy_d, we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, gen_addr;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic xfer, last, clear, legal;
`ifdef OPERAND_ZERO_PAD_EN
    logic pad_start, pad_step, pad_any, pad_last;
    logic [ADDR_WIDTH-1:0] pad_addr;
`endif
    assign s_ready_o = state_q == LOAD;
    assign xfer = s_valid_i && s_ready_o;
    assign legal = n_rows_i != '0 && n_cols_i != '0 &&
                   n_rows_i <= DIM_W'(MAX_DIM) && n_cols_i <= DIM_W'(MAX_DIM);
    operand_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .MAX_DIM   (MAX_DIM),
        .DIM_W     (DIM_W)
    ) u_addr_gen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (clear),
        .step_i     (xfer),
        .n_rows_i   (rows_q),
        .n_cols_i   (cols_q),
`ifdef OPERAND_ZERO_PAD_EN
        .pad_start_i(pad_start),
        .pad_step_i (pad_step),
        .pad_addr_o (pad_addr),
        .pad_any_o  (pad_any),
        .pad_last_o (pad_last),
`endif
        .addr_o     (gen_addr),
        .last_o     (last)
    );
    always_comb begin
        state_d = state_q;
        rows_d = rows_q;
        cols_d = cols_q;
        err_d = err_q;
        we_d = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        clear = 1'b0;
`ifdef OPERAND_ZERO_PAD_EN
        pad_start = 1'b0;
        pad_step = 1'b0;
`endif
        case (state_q)
            IDLE: if (start_i) begin
                err_d = !legal;
                if (legal) begin
                    rows_d = n_rows_i;
                    cols_d = n_cols_i;
                    clear = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: if (xfer) begin
                we_d = 1'b1;
                addr_d = gen_addr;
                data_d = s_data_i;
                if (last) begin
`ifdef OPERAND_ZERO_PAD_EN
                    pad_start = 1'b1;
                    state_d = pad_any ? PAD : DONE;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef OPERAND_ZERO_PAD_EN
            PAD: begin
                we_d = 1'b1;
                addr_d = pad_addr;
                data_d = '0;
                pad_step = 1'b1;
                if (pad_last) state_d = DONE;
            end
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // done trails the DONE state by a cycle so it lands just after the final write; busy covers it.
        done_d = state_q == DONE;
        busy_d = state_d != IDLE || done_d;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rows_q <= '0;
            cols_q <= '0;
            err_q <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            we_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state_q <= state_d;
            rows_q <= rows_d;
            cols_q <= cols_d;
            err_q <= err_d;
            done_q <= done_d;
            busy_q <= busy_d;
            we_q <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o = err_q;
    assign write_en_Mat_o = we_q;
    assign addr_Mat_o = addr_q;
    assign write_data_Mat_o = data_q;
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: table-driven loads plus error and mid-load reset sequences for operand_loader
module tb_operand_loader;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int MD = 4;
    localparam int DIMW = 3;
`ifdef OPERAND_ZERO_PAD_EN
    localparam bit PADF = 1'b1;
`else
    localparam bit PADF = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_i, start_i, s_valid_i;
    logic [DIMW-1:0] n_rows_i, n_cols_i;
    logic [DW-1:0] s_data_i, write_data_Mat_o;
    logic [AW-1:0] addr_Mat_o;
    logic busy_o, done_o, err_o, s_ready_o, write_en_Mat_o;
    always #5 clk = ~clk;
    operand_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_DIM(MD), .DIM_W(DIMW)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .n_rows_i(n_rows_i), .n_cols_i(n_cols_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .s_data_i(s_data_i), .s_valid_i(s_valid_i),
        .s_ready_o(s_ready_o), .write_data_Mat_o(write_data_Mat_o), .addr_Mat_o(addr_Mat_o),
        .write_en_Mat_o(write_en_Mat_o)
    );
    typedef struct {
        int rows;
        int cols;
        int base;
        bit toggle;
        bit poke;
        bit legal;
        int done_cyc;
    } vec_t;
    vec_t vt[9];
    int wa[64], wd[64], wc[64], ac[64];
    int nw, na, nd, dcyc, bfirst, blast, nready;
    int n_cmp = 0, n_bad = 0, cur = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL vec%0d %s: got %0d, expected %0d", cur, nm, got, exp);
        end
    endtask

    task automatic run(input vec_t v);
        bit vld, rdy;
        int k;
        nw = 0; na = 0; nd = 0; dcyc = -1; bfirst = -1; blast = -1; nready = 0; k = 0; vld = 1'b0;
        start_i = 1'b1;
        n_rows_i = DIMW'(v.rows);
        n_cols_i = DIMW'(v.cols);
        s_valid_i = 1'b0;
        rdy = s_ready_o;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start_i = v.poke && c == 3;
            if (v.poke && c == 3) begin
                n_rows_i = 3'd1;
                n_cols_i = 3'd1;
            end
            if (vld && rdy) begin ac[na] = c - 1; na++; k++; end
            if (write_en_Mat_o && nw < 64) begin
                wa[nw] = int'(addr_Mat_o);
                wd[nw] = int'(write_data_Mat_o);
                wc[nw] = c;
                nw++;
            end
            if (done_o) begin nd++; dcyc = c; end
            if (busy_o) begin
                if (bfirst < 0) bfirst = c;
                blast = c;
            end
            if (s_ready_o) nready++;
            rdy = s_ready_o;
            vld = k < v.rows * v.cols && (!v.toggle || c % 2 == 1);
            s_valid_i = vld;
            s_data_i = DW'(v.base + k);
            if ((nd > 0 && c > dcyc) || (!v.legal && c >= 6)) break;
        end
        s_valid_i = 1'b0;
        start_i = 1'b0;
    endtask

    task automatic check_vec(input vec_t v);
        int n, np;
        n = v.legal ? v.rows * v.cols : 0;
        chk("err", int'(err_o), v.legal ? 0 : 1);
        if (!v.legal) begin
            chk("illegal writes", nw, 0);
            chk("illegal done", nd, 0);
            chk("illegal busy", bfirst, -1);
            chk("illegal ready", nready, 0);
        end else begin
            chk("accepts", na, n);
            for (int j = 0; j < n; j++) begin
                chk("data addr", wa[j], (j / v.cols) * MD + j % v.cols);
                chk("data value", wd[j], v.base + j);
                chk("write latency", wc[j], ac[j] + 1);
            end
            np = 0;
            if (PADF) begin
                for (int a = 0; a < MD * MD; a++) begin
                    if (a / MD >= v.rows || a % MD >= v.cols) begin
                        chk("pad addr", wa[n + np], a);
                        chk("pad data", wd[n + np], 0);
                        chk("pad cycle", wc[n + np], wc[n - 1] + 1 + np);
                        np++;
                    end
                end
            end
            chk("write count", nw, n + np);
            chk("done count", nd, 1);
            chk("done cycle", dcyc, v.done_cyc);
            chk("done after last write", dcyc, nw > 0 ? wc[nw - 1] + 1 : -1);
            chk("busy first", bfirst, 1);
            chk("busy last", blast, v.done_cyc);
            chk("ready cycles", nready, ac[n - 1]);
        end
    endtask

    initial begin
        int bad;
        vt[0] = '{4, 4, 1,  1'b0, 1'b0, 1'b1, 18};
        vt[1] = '{2, 3, 10, 1'b0, 1'b0, 1'b1, PADF ? 18 : 8};
        vt[2] = '{2, 3, 10, 1'b1, 1'b0, 1'b1, PADF ? 23 : 13};
        vt[3] = '{4, 2, 40, 1'b1, 1'b1, 1'b1, PADF ? 25 : 17};
        vt[4] = '{0, 2, 0,  1'b0, 1'b0, 1'b0, 0};
        vt[5] = '{2, 5, 0,  1'b0, 1'b0, 1'b0, 0};
        vt[6] = '{1, 1, 7,  1'b0, 1'b0, 1'b1, PADF ? 18 : 3};
        vt[7] = '{3, 1, 50, 1'b0, 1'b0, 1'b1, PADF ? 18 : 5};
        vt[8] = '{1, 4, 60, 1'b0, 1'b0, 1'b1, PADF ? 18 : 6};
        rst_i = 1'b1; start_i = 1'b0; n_rows_i = '0; n_cols_i = '0; s_valid_i = 1'b0; s_data_i = '0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        cur = -1;
        chk("reset busy", int'(busy_o), 0);
        chk("reset done", int'(done_o), 0);
        chk("reset err", int'(err_o), 0);
        chk("reset ready", int'(s_ready_o), 0);
        chk("reset we", int'(write_en_Mat_o), 0);
        chk("reset addr", int'(addr_Mat_o), 0);
        chk("reset data", int'(write_data_Mat_o), 0);
        for (int i = 0; i < 9; i++) begin
            cur = i;
            run(vt[i]);
            check_vec(vt[i]);
        end
        cur = 100;
        start_i = 1'b1; n_rows_i = 3'd4; n_cols_i = 3'd4; s_valid_i = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            s_valid_i = 1'b1;
            s_data_i = DW'(200 + c);
        end
        @(negedge clk);
        chk("pre-abort we", int'(write_en_Mat_o), 1);
        chk("pre-abort addr", int'(addr_Mat_o), 4);
        chk("pre-abort data", int'(write_data_Mat_o), 205);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        s_valid_i = 1'b0;
        chk("abort we", int'(write_en_Mat_o), 0);
        chk("abort ready", int'(s_ready_o), 0);
        chk("abort busy", int'(busy_o), 0);
        chk("abort done", int'(done_o), 0);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (done_o || write_en_Mat_o || busy_o) bad++;
        end
        chk("post-abort activity", bad, 0);
        cur = 101;
        run(vt[0]);
        check_vec(vt[0]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Upstream stage of the matrix operand register file. Takes a stream of matrix elements over a valid/ready handshake.
- Sequences elements into row-major, MAX_DIM-pitched addresses and drives the register file's write port (data, address, write enable).
- One start command loads one matrix of n_rows x n_cols (1..MAX_DIM each), then pulses done.

Parameters:
- DATA_WIDTH, 32, element width; matches the operand register file data width.
- ADDR_WIDTH, 4, register file address width; must equal clog2(MAX_DIM*MAX_DIM).
- MAX_DIM, 4, maximum matrix dimension; the register file holds MAX_DIM*MAX_DIM entries.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  begin a load; sampled only in IDLE.
- n_rows_i  in  DIM_W  row count, sampled with start_i. DIM_W = clog2(MAX_DIM)+1.
- n_cols_i  in  DIM_W  column count, sampled with start_i.
- busy_o  out  1  high whenever state != IDLE.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  sticky flag for illegal dimensions.
- s_data_i  in  DATA_WIDTH  stream element.
- s_valid_i  in  1  stream valid.
- s_ready_o  out  1  stream ready.
- write_data_Mat_o  out  DATA_WIDTH  register file write data.
- addr_Mat_o  out  ADDR_WIDTH  register file address.
- write_en_Mat_o  out  1  register file write enable.

Behaviour:
- Reset: state IDLE; every output 0 (busy, done, err, s_ready, write_en, addr, write_data); row/col counters 0. Reset does not touch register file contents.
- FSM states: IDLE, LOAD, PAD (feature only), DONE.
- IDLE, start_i with 1 <= n_rows_i, n_cols_i <= MAX_DIM:
  - latch dims, clear err_o, zero counters, go to LOAD.
- IDLE, start_i with either dim 0 or > MAX_DIM:
  - set err_o, stay IDLE, no done.
  - err_o stays set until the next legal start or reset.
- start_i outside IDLE is ignored.
- LOAD: s_ready_o = 1 (decoded from state). A transfer occurs when s_valid_i && s_ready_o.
- Each transfer registers, for the next cycle: write_en=1, addr = row*MAX_DIM + col, write_data = s_data_i. Write latency is exactly 1 cycle after acceptance.
- Cycles with no transfer drive write_en=0 on the next cycle; addr and data hold their previous values.
- Counters: col increments per transfer; at n_cols-1 col wraps to 0 and row increments.
- Last element is at row == n_rows-1 and col == n_cols-1. On its transfer, go to PAD (feature enabled) or DONE; s_ready_o is 0 from the next cycle.
- DONE: done_o = 1 for exactly one cycle, aligned with the cycle after the final write_en; then IDLE.
- busy_o is high through LOAD, PAD and DONE.
- Throughput: 1 element/cycle with continuous valid. A 4x4 load issues 16 writes, then done.
- Reset mid-operation: abort to IDLE. write_en is 0 from the cycle after reset is sampled. No done pulse. Entries already written stay written.

Optional Feature:
- Macro: OPERAND_ZERO_PAD_EN.
- Defined: after the last element, PAD state writes 0 to every address with row >= n_rows or col >= n_cols.
  - Ascending address order, one write per cycle, s_ready_o = 0.
  - Then DONE. Skipped (straight to DONE) when n_rows = n_cols = MAX_DIM.
- Undefined: no PAD state; unused entries keep their previous contents.

Decomposition:
- Package operand_pkg: MAX_DIM, DIM_W, state enum (IDLE/LOAD/PAD/DONE), address-compose function row*MAX_DIM+col.
- One natural sub-module: operand_addr_gen. Row/col counters with wrap, last-element flag, and pad-address scan.
- The FSM and output registers stay in operand_loader.

Test Plan:
- start, 4x4, s_valid held high, data 1..16, start sampled cycle 0:
  - writes at cycles 2..17, addr 0..15, data 1..16; done_o at cycle 18 only; busy_o high cycles 1..18.
- start, 2x3, data 10..15:
  - write addrs 0,1,2,4,5,6 carry data 10..15; with the feature off, no other writes, then done.
- 2x3 with valid toggling every other cycle:
  - write_en exactly 1 cycle after each accept; 6 writes total; no write on bubble cycles; addr/data sequence unchanged.
- start with n_rows=0, then with n_cols=5:
  - err_o=1, busy_o stays 0, no writes, no done.
  - A following legal 1x1 start clears err_o and writes addr 0.
- rst_i asserted after 5 accepts of a 4x4 load:
  - next cycle state IDLE, write_en=0, s_ready_o=0, no done.
  - A new 4x4 start restarts at addr 0.
- OPERAND_ZERO_PAD_EN, 2x3:
  - after the 6 data writes, 10 zero writes at addrs 3,7,8..15 in order, then done; s_ready_o low throughout PAD.
